// File: rtl/cpu_pkg.sv
// Shared definitions for the execute/writeback sequencer: ALU codops,
// sequencer states, instruction field positions and datapath sizing.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 16;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLTI = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_ANDI = 4'd6;
    localparam logic [3:0] ALU_ORI  = 4'd7;
    localparam logic [3:0] ALU_XORI = 4'd8;
    localparam logic [3:0] ALU_ADDI = 4'd9;
    localparam logic [3:0] ALU_SUBI = 4'd10;
    localparam logic [3:0] ALU_NOP  = 4'd15;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } seq_state_e;

    // R-type ops take both operands from the register file, b = R[rs], a = R[rt].
    function automatic logic is_rtype(input logic [3:0] codop);
        logic r;
        case (codop)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_legal(input logic [3:0] codop);
        return (codop <= ALU_SUBI);
    endfunction

endpackage

// File: rtl/alu_sequencer_reg_file16.sv
// Architectural register file: two async operand reads, one async debug read,
// one synchronous write port; R0 is hardwired to zero.
module reg_file16 #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int NREGS  = cpu_pkg::NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        i_rs_addr,
    input  logic [3:0]        i_rt_addr,
    input  logic [3:0]        i_dbg_addr,
    input  logic              i_we,
    input  logic [3:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_mem [NREGS];

    // Register storage with async clear; writes to R0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (i_we && (i_waddr != 4'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rs_data  = (i_rs_addr  == 4'd0) ? {DATA_W{1'b0}} : r_mem[i_rs_addr];
    assign o_rt_data  = (i_rt_addr  == 4'd0) ? {DATA_W{1'b0}} : r_mem[i_rt_addr];
    assign o_dbg_data = (i_dbg_addr == 4'd0) ? {DATA_W{1'b0}} : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue execute/writeback sequencer: accepts an instruction, presents
// held operands to an external registered ALU, then writes back and latches flags.
module alu_sequencer #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int NREGS  = cpu_pkg::NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [3:0]        alu_codop,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_neg,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic [2:0]        flags,
    output logic              done,
    output logic              illegal,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    import cpu_pkg::*;

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic              w_accept;
    logic              w_legal;
    logic              w_retire;

    logic [3:0]        w_opc;
    logic [3:0]        w_rd;
    logic [3:0]        w_rs;
    logic [3:0]        w_rt;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_opd_a;
    logic [DATA_W-1:0] w_opd_b;

    logic [3:0]        r_codop;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [3:0]        r_rd;
    logic [2:0]        r_flags;
    logic              r_done;
    logic              r_illegal;

    assign w_opc = instr[OPC_HI:OPC_LO];
    assign w_rd  = instr[RD_HI:RD_LO];
    assign w_rs  = instr[RS_HI:RS_LO];
    assign w_rt  = instr[RT_HI:RT_LO];
    assign w_imm = {{(DATA_W-4){1'b0}}, w_rt};

    reg_file16 #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_reg_file (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rs_addr  (w_rs),
        .i_rt_addr  (w_rt),
        .i_dbg_addr (dbg_addr),
        .i_we       (w_retire),
        .i_waddr    (r_rd),
        .i_wdata    (alu_out),
        .o_rs_data  (w_rs_data),
        .o_rt_data  (w_rt_data),
        .o_dbg_data (dbg_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; an illegal opcode is consumed without leaving IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_legal     = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid) begin
                    w_accept = 1'b1;
                    if (is_legal(w_opc)) begin
                        w_legal     = 1'b1;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: w_state_nxt = ST_WB;
            ST_WB: begin
                w_retire    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand routing: R-type swaps the register operands onto b/a.
    always_comb begin
        w_opd_a = {DATA_W{1'b0}};
        w_opd_b = {DATA_W{1'b0}};
        if (is_rtype(w_opc)) begin
            w_opd_a = w_rt_data;
            w_opd_b = w_rs_data;
        end else begin
            w_opd_a = w_rs_data;
            w_opd_b = w_imm;
        end
    end

    // ALU drive, writeback target, flags and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_codop   <= ALU_NOP;
            r_alu_a   <= {DATA_W{1'b0}};
            r_alu_b   <= {DATA_W{1'b0}};
            r_rd      <= 4'd0;
            r_flags   <= 3'b000;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done    <= w_retire;
            r_illegal <= w_accept & ~w_legal;
            if (w_accept && w_legal) begin
                r_codop <= w_opc;
                r_alu_a <= w_opd_a;
                r_alu_b <= w_opd_b;
                r_rd    <= w_rd;
            end else if (w_retire) begin
                r_codop <= ALU_NOP;
                r_alu_a <= {DATA_W{1'b0}};
                r_alu_b <= {DATA_W{1'b0}};
            end
            // Overflow is combinational in the ALU; operands are still held here.
            if (w_retire) begin
                r_flags <= {alu_neg, alu_zero, alu_overflow};
            end
        end
    end

    assign instr_ready = (r_state == ST_IDLE);
    assign alu_codop   = r_codop;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign flags       = r_flags;
    assign done        = r_done;
    assign illegal     = r_illegal;

endmodule
